// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and sizing helper for the bit-serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Bit-position counter width; never below one bit so a WIDTH of 2 still gets a real register.
  function automatic int cnt_w(input int width);
    return (width < 3) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - combinational one-bit full subtractor cell
module full_subtractor_bit (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  // Difference bit and borrow-out of a - b - bin.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first; SERIAL_SUB_OVF_EN adds the ovf port
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t state;
  sub_state_t next_state;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             bflop;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  full_subtractor_bit u_cell (
    .d    (cell_d),
    .bout (cell_bout),
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bflop)
  );

  // Accumulated result with this cycle's bit placed at the MSB; the LSB falls off on the final shift.
  assign sr_next  = {cell_d, sr};
  assign accept   = start & ready;
  assign last_bit = (state == SHIFT) && (cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the handshake outputs derived from the current state.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next_state = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST_BIT) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand shifters, borrow flop and bit counter: load on accept, step once per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      bflop <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      bflop <= 1'b0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sa    <= {1'b0, sa[WIDTH-1:1]};
      sb    <= {1'b0, sb[WIDTH-1:1]};
      sr    <= sr_next[WIDTH-1:1];
      bflop <= cell_bout;
      cnt   <= cnt + 1'b1;
    end
  end

  // Result registers update only on the final bit and hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
    end else if (last_bit) begin
      diff   <= sr_next;
      borrow <= cell_bout;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  // Operand sign bits are shifted out during the op, so keep copies for the overflow check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last_bit) begin
      ovf <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end
`endif

endmodule
